// File: rtl/serial_adder_n.sv
// serial_adder_n
// Bit-serial adder/subtractor. One full-add step per clock, LSB first, built
// from two half-adder stages and a carry flip-flop. Operands are latched on an
// accepted start; the result registers update only when the last bit is done.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; result registers hold the previous result
// BUSY  | one operand bit per clock, WIDTH clocks in total
// DONE  | result valid and new, done pulses for one cycle, then IDLE

module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic             c;
  logic [CW-1:0]    cnt;

  logic ha1_s, ha1_c, ha2_c;
  logic s_bit, c_nx, last_bit;

  // Two half-adder stages form the full-add step on the current LSBs
  always_comb begin
    ha1_s    = a_sh[0] ^ b_sh[0];
    ha1_c    = a_sh[0] & b_sh[0];
    s_bit    = ha1_s ^ c;
    ha2_c    = ha1_s & c;
    c_nx     = ha1_c | ha2_c;
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_BUSY;
      S_BUSY:  if (last_bit) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode from the state register only
  always_comb begin
    busy = (state == S_BUSY);
    done = (state == S_DONE);
  end

  // Operand shifters, carry, bit counter and result registers.
  // The carry into the MSB is the current c on the last step, so signed
  // overflow is taken directly as c ^ c_nx without a separate holding flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      s_sh <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= sub ? ~b : b;
            c    <= sub ? 1'b1 : cin;
            cnt  <= '0;
          end
        end
        S_BUSY: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          s_sh <= {s_bit, s_sh[WIDTH-1:1]};
          c    <= c_nx;
          if (last_bit) begin
            sum  <= {s_bit, s_sh[WIDTH-1:1]};
            cout <= c_nx;
            ovf  <= c ^ c_nx;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// Testbench for serial_adder_n: directed WIDTH=8 vectors plus a WIDTH=16
// random run against an arithmetic reference.

module tb_serial_adder_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // WIDTH=8 instance
  logic       start8 = 0, sub8 = 0, cin8 = 0;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic       cout8, ovf8, busy8, done8;

  serial_adder_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .cin(cin8), .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8)
  );

  // WIDTH=16 instance
  logic        start16 = 0, sub16 = 0, cin16 = 0;
  logic [15:0] a16 = 0, b16 = 0, sum16;
  logic        cout16, ovf16, busy16, done16;

  serial_adder_n #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .cin(cin16), .sum(sum16), .cout(cout16), .ovf(ovf16), .busy(busy16), .done(done16)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Runs one WIDTH=8 operation starting #1 after an edge. lat counts edges
  // from the accepting edge (inclusive) until done is seen; returns in IDLE.
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                      input logic isub, output logic [7:0] os, output logic oc,
                      output logic oo, output int lat, output int nbusy);
    a8 = ia; b8 = ib; cin8 = icin; sub8 = isub; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = ~ia; b8 = ~ib; cin8 = ~icin; sub8 = ~isub;
    lat = 1;
    nbusy = busy8 ? 1 : 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy8) nbusy++;
    end
    os = sum8; oc = cout8; oo = ovf8;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    ncmp++;
    if ({sum8, cout8, ovf8, busy8, done8} !== 12'h000) begin
      nerr++;
      $display("FAIL reset8: got sum=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
               sum8, cout8, ovf8, busy8, done8);
    end
    ncmp++;
    if ({sum16, cout16, ovf16, busy16, done16} !== 20'h00000) begin
      nerr++;
      $display("FAIL reset16: got sum=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
               sum16, cout16, ovf16, busy16, done16);
    end
  endtask

  task automatic test_add();
    logic [7:0] s; logic c, o; int lat, nb;
    run8(8'h5A, 8'h33, 1'b0, 1'b0, s, c, o, lat, nb);
    ncmp++;
    if ({s, c, o} !== {8'h8D, 1'b0, 1'b1}) begin
      nerr++;
      $display("FAIL add_5a_33: got sum=%h cout=%b ovf=%b, want 8d 0 1", s, c, o);
    end
    ncmp++;
    if (lat !== 9) begin
      nerr++;
      $display("FAIL latency8: got %0d edges, want 9", lat);
    end
    ncmp++;
    if (done8 !== 1'b0) begin
      nerr++;
      $display("FAIL done_pulse: done still %b one cycle later, want 0", done8);
    end
    run8(8'hFF, 8'h01, 1'b0, 1'b0, s, c, o, lat, nb);
    ncmp++;
    if ({s, c, o} !== {8'h00, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL add_ff_01: got sum=%h cout=%b ovf=%b, want 00 1 0", s, c, o);
    end
    run8(8'h00, 8'h00, 1'b1, 1'b0, s, c, o, lat, nb);
    ncmp++;
    if ({s, c, o} !== {8'h01, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL add_cin: got sum=%h cout=%b ovf=%b, want 01 0 0", s, c, o);
    end
  endtask

  task automatic test_sub();
    logic [7:0] s; logic c, o; int lat, nb;
    run8(8'h10, 8'h20, 1'b1, 1'b1, s, c, o, lat, nb);
    ncmp++;
    if ({s, c, o} !== {8'hF0, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL sub_10_20: got sum=%h cout=%b ovf=%b, want f0 0 0", s, c, o);
    end
    run8(8'h80, 8'h01, 1'b0, 1'b1, s, c, o, lat, nb);
    ncmp++;
    if ({s, c, o} !== {8'h7F, 1'b1, 1'b1}) begin
      nerr++;
      $display("FAIL sub_80_01: got sum=%h cout=%b ovf=%b, want 7f 1 1", s, c, o);
    end
  endtask

  // Previous result is 0x7F/1/1; run 0x12+0x34=0x46 with stray starts in BUSY/DONE
  task automatic test_ignore_start();
    int nb = 0, ndone = 0, held_bad = 0;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;                        // E0
    start8 = 1'b0;
    if (busy8) nb++;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3 || k == 9) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; sub8 = 1'b1;
      end
      @(posedge clk); #1;                      // edge E0+k
      start8 = 1'b0;
      if (busy8) nb++;
      if (done8) ndone++;
      if (k < 8 && sum8 !== 8'h7F) held_bad++;
    end
    ncmp++;
    if (held_bad !== 0) begin
      nerr++;
      $display("FAIL hold_during_busy: %0d cycles changed sum, want 0", held_bad);
    end
    ncmp++;
    if (nb !== 8) begin
      nerr++;
      $display("FAIL busy_len: busy high %0d cycles, want 8", nb);
    end
    ncmp++;
    if (ndone !== 1) begin
      nerr++;
      $display("FAIL single_done: %0d done pulses, want 1", ndone);
    end
    ncmp++;
    if ({sum8, cout8, ovf8} !== {8'h46, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL ignore_start_result: got sum=%h cout=%b ovf=%b, want 46 0 0",
               sum8, cout8, ovf8);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] s; logic c, o; int lat, nb, nd = 0;
    // sum currently 0x46; start 0xC3+0x11 and abort at 4th BUSY cycle
    a8 = 8'hC3; b8 = 8'h11; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    ncmp++;
    if ({sum8, cout8, ovf8, busy8, done8} !== 12'h000) begin
      nerr++;
      $display("FAIL mid_reset: got sum=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
               sum8, cout8, ovf8, busy8, done8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8 || busy8) nd++;
    end
    ncmp++;
    if (nd !== 0) begin
      nerr++;
      $display("FAIL no_done_after_reset: %0d busy/done cycles, want 0", nd);
    end
    run8(8'h7F, 8'h01, 1'b0, 1'b0, s, c, o, lat, nb);
    ncmp++;
    if ({s, c, o, lat} !== {8'h80, 1'b1 & 1'b0, 1'b1, 32'd9}) begin
      nerr++;
      $display("FAIL after_reset_op: got sum=%h cout=%b ovf=%b lat=%0d, want 80 0 1 9",
               s, c, o, lat);
    end
  endtask

  task automatic test_random16();
    logic [16:0] ref_full;
    logic [15:0] bb, rs;
    logic        rc, ro, ic;
    int t0, tprev, lat, nbad = 0, nspace = 0, nto = 0;
    tprev = 0;
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom);
      cin16 = 1'($urandom); sub16 = 1'($urandom);
      if (i == 0) begin a16 = 16'h7FFF; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0; end
      if (i == 1) begin a16 = 16'h0000; b16 = 16'h0001; cin16 = 1'b1; sub16 = 1'b1; end
      bb = sub16 ? ~b16 : b16;
      ic = sub16 ? 1'b1 : cin16;
      ref_full = {1'b0, a16} + {1'b0, bb} + {16'd0, ic};
      rs = ref_full[15:0];
      rc = ref_full[16];
      ro = (a16[15] == bb[15]) && (rs[15] != a16[15]);
      start16 = 1'b1;
      @(posedge clk); #1;
      t0 = cyc;
      start16 = 1'b0;
      a16 = ~a16; b16 = ~b16;
      lat = 1;
      while (!done16 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      if (lat !== 17) nto++;
      if ({sum16, cout16, ovf16} !== {rs, rc, ro}) begin
        nbad++;
        if (nbad <= 5)
          $display("FAIL rand16[%0d]: got sum=%h cout=%b ovf=%b, want %h %b %b",
                   i, sum16, cout16, ovf16, rs, rc, ro);
      end
      if (i > 0 && (t0 - tprev) !== 18) nspace++;
      tprev = t0;
      @(posedge clk); #1;
    end
    ncmp++;
    if (nbad !== 0) begin
      nerr++;
      $display("FAIL rand16_results: %0d wrong of 1000, want 0", nbad);
    end
    ncmp++;
    if (nto !== 0) begin
      nerr++;
      $display("FAIL rand16_latency: %0d ops not 17 edges, want 0", nto);
    end
    ncmp++;
    if (nspace !== 0) begin
      nerr++;
      $display("FAIL rand16_spacing: %0d starts not 18 cycles apart, want 0", nspace);
    end
  endtask

  initial begin
    test_reset();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    test_add();
    test_sub();
    test_ignore_start();
    test_mid_reset();
    test_random16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
